// File: rtl/otp_keygen_pkg.sv
// otp_keygen_pkg: shared word size, LFSR defaults and FSM encoding for otp_keygen.
// MSG_SIZE may be supplied on the command line; it falls back to 8.
`ifndef MSG_SIZE
`define MSG_SIZE 8
`endif

package otp_keygen_pkg;

  localparam int MSG_W = `MSG_SIZE;
  localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);

  localparam int          DEF_LFSR_W = 32;
  localparam logic [31:0] DEF_TAPS   = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED   = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/otp_lfsr.sv
// otp_lfsr: right-shifting Galois LFSR; out_bit is the bit leaving on the next step.
// A zero load value is replaced by DEFAULT_SEED so the register can never lock up at zero.
module otp_lfsr #(
  parameter int           W            = 32,
  parameter logic [W-1:0] TAPS         = W'(32'h8020_0003),
  parameter logic [W-1:0] DEFAULT_SEED = W'(32'h0000_0001)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state,
  output logic         out_bit
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_val == '0) ? DEFAULT_SEED : load_val;
    end else if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state   = lfsr_q;
  assign out_bit = lfsr_q[0];

endmodule

// File: rtl/otp_keygen.sv
// otp_keygen: packs the otp_lfsr keystream into MSG_W-bit one-time-pad words for the cypher.
// Define OTP_PREFETCH_EN to let HOLD assemble the next word, giving back-to-back keys.
module otp_keygen
  import otp_keygen_pkg::*;
#(
  parameter int                LFSR_W       = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              key_ready,
  output logic              key_valid,
  output logic [MSG_W-1:0]  otp,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [LFSR_W-1:0] dbg_lfsr
);

  // key_valid/key_ready: a key transfers on every rising edge where both are high; otp is
  // stable while key_valid is high and untaken, and key_ready alone has no effect.

`ifdef OTP_PREFETCH_EN
  localparam int ASM_W = MSG_W;
`else
  localparam int ASM_W = MSG_W - 1;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic [MSG_W-1:0]   otp_q, otp_d;
  logic               valid_q, valid_d;
  logic               lfsr_load, lfsr_step, lfsr_bit;
  logic [MSG_W-1:0]   word_now;
  logic               cnt_last;
`ifdef OTP_PREFETCH_EN
  logic               nxt_full_q, nxt_full_d;
`endif

  otp_lfsr #(
    .W            (LFSR_W),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .state    (dbg_lfsr),
    .out_bit  (lfsr_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    otp_d     = otp_q;
    valid_d   = valid_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef OTP_PREFETCH_EN
    nxt_full_d = nxt_full_q;
`endif
    // The word completing this cycle: earlier bits move up, the live LFSR bit enters at the LSB.
    word_now = {asm_q[MSG_W-2:0], lfsr_bit};
    cnt_last = (cnt_q == CNT_LAST);

    if (seed_load) begin
      lfsr_load = 1'b1;
      cnt_d     = '0;
      valid_d   = 1'b0;
      state_d   = ST_IDLE;
`ifdef OTP_PREFETCH_EN
      nxt_full_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_GEN;
        end
        ST_GEN: begin
          lfsr_step = 1'b1;
          asm_d     = word_now[ASM_W-1:0];
          if (cnt_last) begin
            otp_d   = word_now;
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
`ifdef OTP_PREFETCH_EN
          if (!nxt_full_q) begin
            lfsr_step = 1'b1;
            asm_d     = word_now;
            cnt_d     = cnt_last ? '0 : cnt_q + CNT_W'(1);
          end
          if (valid_q && key_ready) begin
            if (nxt_full_q) begin
              otp_d      = asm_q;
              nxt_full_d = 1'b0;
            end else if (cnt_last) begin
              otp_d = word_now;
            end else begin
              // Partial prefetch: finish the word in GEN from the preserved count.
              valid_d = 1'b0;
              state_d = ST_GEN;
            end
          end else if (!nxt_full_q && cnt_last) begin
            nxt_full_d = 1'b1;
          end
`else
          if (valid_q && key_ready) begin
            valid_d = 1'b0;
            state_d = enable ? ST_GEN : ST_IDLE;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      otp_q   <= '0;
      valid_q <= 1'b0;
`ifdef OTP_PREFETCH_EN
      nxt_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      otp_q   <= otp_d;
      valid_q <= valid_d;
`ifdef OTP_PREFETCH_EN
      nxt_full_q <= nxt_full_d;
`endif
    end
  end

  assign key_valid = valid_q;
  assign otp       = otp_q;
  assign busy      = (state_q == ST_GEN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_otp_keygen.sv
// tb_otp_keygen: directed scenarios with random seeds/handshakes, checked against a
// bit-serial keystream model (OTP_PREFETCH_EN selects the expected key period).
`timescale 1ns/1ps
module tb_otp_keygen;
  import otp_keygen_pkg::*;

  localparam int          LW       = 32;
  localparam logic [31:0] M_TAPS   = 32'h8020_0003;
  localparam int          MAX_WAIT = 400;
`ifdef OTP_PREFETCH_EN
  localparam int          PERIOD   = MSG_W;
`else
  localparam int          PERIOD   = MSG_W + 1;
`endif

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             seed_load = 1'b0;
  logic [LW-1:0]    seed = '0;
  logic             key_ready = 1'b0;
  logic             key_valid;
  logic [MSG_W-1:0] otp;
  logic             busy;
  logic [1:0]       dbg_state;
  logic [LW-1:0]    dbg_lfsr;

  always #5 clk = ~clk;

  otp_keygen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .seed_load (seed_load),
    .seed      (seed),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .otp       (otp),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  // ---------------- scoreboard / reference model ----------------
  int               checks = 0;
  int               errors = 0;
  logic [MSG_W-1:0] exp_q[$];
  logic [LW-1:0]    m_lfsr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] m_step(input logic [LW-1:0] s);
    return s[0] ? ((s >> 1) ^ M_TAPS) : (s >> 1);
  endfunction

  task automatic model_seed(input logic [LW-1:0] s);
    m_lfsr = (s == '0) ? 32'h1 : s;
    exp_q.delete();
  endtask

  // Each word collects MSG_W successive output bits, the first one ending up as the MSB.
  task automatic model_push(input int n);
    int unsigned w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      for (int i = 0; i < MSG_W; i++) begin
        w = w * 2 + int'(m_lfsr[0]);
        m_lfsr = m_step(m_lfsr);
      end
      exp_q.push_back(MSG_W'(w));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_valid(output int lat, output int bcnt);
    int cyc;
    int first;
    cyc = 0; first = -1; bcnt = 0; lat = -1;
    while (cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) begin
        bcnt++;
        if (first < 0) first = cyc;
      end
      if (key_valid === 1'b1) begin
        lat = (first < 0) ? -1 : cyc - first;
        break;
      end
    end
    check("key_valid_arrives", key_valid, 1'b1);
  endtask

  task automatic pulse_seed(input logic [LW-1:0] s);
    seed      = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [MSG_W-1:0] w0;
  logic [MSG_W-1:0] ct;
  logic [LW-1:0]    s_new;
  int               lat, bcnt, got, cyc, last_cyc;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_otp", otp, '0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_lfsr", dbg_lfsr, 32'h1);
    rst_n = 1'b1;

    // First key from the reset seed
    model_seed(32'h1);
    model_push(1);
    w0 = exp_q[0];
    enable = 1'b1;
    key_ready = 1'b0;
    wait_valid(lat, bcnt);
    check("first_latency", lat, MSG_W);
    check("first_busy_cycles", bcnt, MSG_W);
    check("first_otp", otp, exp_q.pop_front());
    check("hold_busy_low", busy, 1'b0);
    check("hold_state", dbg_state, ST_HOLD);
    repeat (3) @(negedge clk);
    check("hold_otp_stable", otp, w0);
    check("hold_valid_stable", key_valid, 1'b1);

    // seed_load with zero seed beats a simultaneous handshake
    enable = 1'b0;
    key_ready = 1'b1;
    pulse_seed('0);
    key_ready = 1'b0;
    check("zseed_lfsr", dbg_lfsr, 32'h1);
    check("zseed_valid", key_valid, 1'b0);
    check("zseed_state", dbg_state, ST_IDLE);
    check("zseed_otp_kept", otp, w0);

    // Continuous streaming: same keystream as after reset, fixed key period
    model_seed(32'h1);
    model_push(5);
    enable = 1'b1;
    key_ready = 1'b1;
    got = 0; cyc = 0; last_cyc = 0;
    while (got < 5 && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      if (key_valid === 1'b1 && key_ready) begin
        if (got == 0) check("stream_first_eq_reset_key", otp, w0);
        check("stream_otp", otp, exp_q.pop_front());
        if (got > 0) check("stream_period", cyc - last_cyc, PERIOD);
        last_cyc = cyc;
        got++;
      end
    end
    check("stream_keys", got, 5);
    @(negedge clk);
    enable = 1'b0;
    key_ready = 1'b0;
    pulse_seed('0);

    // seed_load on the GEN cycle with counter = 5
    s_new = $urandom;
    enable = 1'b1;
    cyc = 0;
    while (busy !== 1'b1 && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
    end
    check("midgen_busy_start", busy, 1'b1);
    repeat (5) @(negedge clk);
    check("midgen_busy_cnt5", busy, 1'b1);
    pulse_seed(s_new);
    check("midgen_valid", key_valid, 1'b0);
    check("midgen_state", dbg_state, ST_IDLE);
    check("midgen_lfsr", dbg_lfsr, (s_new == '0) ? 32'h1 : s_new);
    model_seed(s_new);
    model_push(1);
    wait_valid(lat, bcnt);
    check("midgen_busy_cycles", bcnt, MSG_W);
    check("midgen_otp", otp, exp_q[0]);

    // Random enable/key_ready: consumed keys follow the keystream with nothing lost or repeated
    model_push(5);
    got = 0; cyc = 0;
    while (got < 6 && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      key_ready = ($urandom_range(0, 1) == 1);
      enable    = ($urandom_range(0, 3) != 0);
      if (key_valid === 1'b1 && key_ready) begin
        check("rand_otp", otp, exp_q.pop_front());
        got++;
      end
    end
    check("rand_keys", got, 6);
    @(negedge clk);
    key_ready = 1'b0;
    enable = 1'b1;

    // Asynchronous reset while a key is held
    wait_valid(lat, bcnt);
    #2 rst_n = 1'b0;
    #1;
    check("arst_otp", otp, '0);
    check("arst_valid", key_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_lfsr", dbg_lfsr, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset key and cypher round trip
    model_seed(32'h1);
    model_push(1);
    wait_valid(lat, bcnt);
    check("post_rst_latency", lat, MSG_W);
    check("post_rst_otp", otp, exp_q[0]);
    ct = MSG_W'(8'hA5) ^ otp;
    check("cipher_text", ct, MSG_W'(8'hA5) ^ exp_q[0]);
    check("cipher_recover", ct ^ otp, MSG_W'(8'hA5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
